// File: rtl/vend_sequencer_if.sv
// Coin-slot / dispenser signal bundle for vend_sequencer.
// master: coin slot + dispenser side (drives coin, cancel, disp_ack).
// slave:  the sequencer itself.
interface vend_sequencer_if #(
    parameter int CREDIT_W = 4
);
    logic [1:0]          coin;
    logic                cancel;
    logic                disp_ack;
    logic                disp_req;
    logic                newspaper;
    logic                change_nickel;
    logic                coin_reject;
    logic                fault;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin, cancel, disp_ack,
        input  disp_req, newspaper, change_nickel, coin_reject, fault, credit, busy
    );

    modport slave (
        input  coin, cancel, disp_ack,
        output disp_req, newspaper, change_nickel, coin_reject, fault, credit, busy
    );
endinterface

// File: rtl/vend_sequencer.sv
// Newspaper vending controller: coin decode, credit accumulation, price
// check, dispenser request/ack handshake with timeout, change return.
// Optional feature macro: CHANGE_RETURN_EN (defined: refunds/change are paid
// out as change_nickel pulses; undefined: legacy forfeit/retry behaviour).
module vend_sequencer #(
    parameter int PRICE        = 3,
    parameter int CREDIT_W     = 4,
    parameter int MAX_CREDIT   = 15,
    parameter int DISP_TIMEOUT = 8
) (
    input  logic             clock,
    input  logic             reset,
    vend_sequencer_if.slave  bus
);
    localparam int SUM_W   = CREDIT_W + 1;
    localparam int TIMER_W = (DISP_TIMEOUT > 1) ? $clog2(DISP_TIMEOUT) : 1;
    localparam logic [SUM_W-1:0]   PRICE_S    = SUM_W'(PRICE);
    localparam logic [SUM_W-1:0]   MAX_S      = SUM_W'(MAX_CREDIT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DISP_TIMEOUT - 1);
`ifdef CHANGE_RETURN_EN
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [1:0]          r_coin_q;
    logic [CREDIT_W-1:0] r_credit, w_credit_next;
    logic [TIMER_W-1:0]  r_timer, w_timer_next;
    logic                r_newspaper, w_newspaper_next;
    logic                r_coin_reject, w_coin_reject_next;
    logic                r_fault, w_fault_next;
`ifdef CHANGE_RETURN_EN
    logic                r_change_nickel, w_change_nickel_next;
`endif

    logic                w_event;
    logic                w_cancel;
    logic [SUM_W-1:0]    w_coin_val;
    logic [SUM_W-1:0]    w_sum;
    logic [SUM_W-1:0]    w_credit_upd;

    // A coin counts only on its rising edge out of the "no coin" code.
    assign w_event = (bus.coin != 2'd0) && (r_coin_q == 2'd0);
    // Sum kept one bit wider than the credit so an overflow is visible.
    assign w_sum   = {1'b0, r_credit} + w_coin_val;

`ifdef CHANGE_RETURN_EN
    assign w_cancel = bus.cancel;
`else
    // Legacy machine has no refund path: cancel never has an effect.
    assign w_cancel = 1'b0;
`endif

    // Decode coin code into its value in nickels.
    always_comb begin
        w_coin_val = '0;
        case (bus.coin)
            2'd1:    w_coin_val = SUM_W'(1);
            2'd2:    w_coin_val = SUM_W'(2);
            2'd3:    w_coin_val = SUM_W'(5);
            default: w_coin_val = '0;
        endcase
    end

    // Next-state, next-credit and pulse decisions.
    always_comb begin
        w_state_next       = r_state;
        w_credit_next      = r_credit;
        w_timer_next       = '0;
        w_newspaper_next   = 1'b0;
        w_coin_reject_next = 1'b0;
        w_fault_next       = 1'b0;
        w_credit_upd       = {1'b0, r_credit};
`ifdef CHANGE_RETURN_EN
        w_change_nickel_next = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_event) begin
                    w_credit_next = w_coin_val[CREDIT_W-1:0];
                    w_state_next  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // cancel beats a coin arriving in the same cycle
                if (w_cancel) begin
                    w_coin_reject_next = w_event;
                    w_state_next       = S_CHANGE;
                end else begin
                    if (w_event) begin
                        if (w_sum <= MAX_S) w_credit_upd = w_sum;
                        else                w_coin_reject_next = 1'b1;
                    end
                    w_credit_next = w_credit_upd[CREDIT_W-1:0];
                    if (w_credit_upd >= PRICE_S) w_state_next = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                w_coin_reject_next = w_event;
                // ack is tested first so it wins over a same-cycle expiry
                if (bus.disp_ack) begin
                    w_newspaper_next = 1'b1;
`ifdef CHANGE_RETURN_EN
                    w_credit_next    = r_credit - PRICE_C;
                    w_state_next     = S_CHANGE;
`else
                    w_credit_next    = '0;
                    w_state_next     = S_IDLE;
`endif
                end else if (r_timer == TIMER_LAST) begin
                    w_fault_next = 1'b1;
`ifdef CHANGE_RETURN_EN
                    w_state_next = S_CHANGE;
`else
                    w_state_next = S_COLLECT;
`endif
                end else begin
                    w_timer_next = r_timer + 1'b1;
                end
            end
            S_CHANGE: begin
                w_coin_reject_next = w_event;
`ifdef CHANGE_RETURN_EN
                if (r_credit == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_change_nickel_next = 1'b1;
                    w_credit_next        = r_credit - 1'b1;
                    if (r_credit == CREDIT_W'(1)) w_state_next = S_IDLE;
                end
`else
                w_state_next = S_IDLE;
`endif
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Datapath registers: coin edge detector, credit, dispense timer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_coin_q <= 2'd0;
            r_credit <= '0;
            r_timer  <= '0;
        end else begin
            r_coin_q <= bus.coin;
            r_credit <= w_credit_next;
            r_timer  <= w_timer_next;
        end
    end

    // Registered one-cycle output pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_newspaper   <= 1'b0;
            r_coin_reject <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_newspaper   <= w_newspaper_next;
            r_coin_reject <= w_coin_reject_next;
            r_fault       <= w_fault_next;
        end
    end

`ifdef CHANGE_RETURN_EN
    // Change pulse register, only present when change return is built in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_change_nickel <= 1'b0;
        else       r_change_nickel <= w_change_nickel_next;
    end
    assign bus.change_nickel = r_change_nickel;
`else
    assign bus.change_nickel = 1'b0;
`endif

    assign bus.disp_req    = (r_state == S_DISPENSE);
    assign bus.busy        = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
    assign bus.credit      = r_credit;
    assign bus.newspaper   = r_newspaper;
    assign bus.coin_reject = r_coin_reject;
    assign bus.fault       = r_fault;
endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
- Controller that fronts the newspaper vending datapath.
- Decodes raw coin inputs into a credit count and compares the credit against a programmable price.
- Sequences a request/acknowledge handshake with a shared dispenser unit, then returns change or refunds one nickel per cycle.
- Sits between the coin slot and the dispenser; the dispenser only acts on disp_req.

Parameters:
- PRICE, 3, item price in nickels (3 = 15 cents).
- CREDIT_W, 4, width of the credit register.
- MAX_CREDIT, 15, highest credit accepted; must be at most 2^CREDIT_W-1 and at least PRICE.
- DISP_TIMEOUT, 8, cycles to wait for disp_ack before aborting.

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- coin  input  2  coin code: 0 none, 1 nickel (+1), 2 dime (+2), 3 quarter (+5).
- cancel  input  1  request refund of the current credit.
- disp_ack  input  1  dispenser has delivered the item.
- disp_req  output  1  dispense request to the dispenser.
- newspaper  output  1  one-cycle pulse when a vend completes.
- change_nickel  output  1  one-cycle pulse per nickel returned.
- coin_reject  output  1  one-cycle pulse when a coin event is not credited.
- fault  output  1  one-cycle pulse on dispenser timeout.
- credit  output  CREDIT_W  current credit in nickels.
- busy  output  1  high in the DISPENSE and CHANGE states.

Behaviour:
- Reset: asynchronous, active-high; clock and reset are the only timing inputs.
  - While reset is high: state=IDLE, credit=0, coin_q=0, timer=0, and all outputs are 0.
- Coin event: coin!=0 and coin_q==0, where coin_q is coin registered each cycle.
  - A coin held for several cycles counts once.
  - Changing directly from one nonzero code to another is not an event.
- State IDLE (credit==0):
  - On an event with value v, set credit=v and go to COLLECT.
  - cancel is ignored.
- State COLLECT:
  - On an event, if credit+v<=MAX_CREDIT then credit+=v; otherwise the credit is unchanged and coin_reject pulses.
  - The sum is computed at CREDIT_W+1 bits, so there is no wrap-around.
  - Priority within a cycle: cancel first, then the coin event, then the price check.
  - cancel in the same cycle as an event: the coin is rejected (coin_reject pulses) and the state goes to CHANGE with the existing credit.
  - Price check: if the updated credit is at least PRICE, go to DISPENSE on the next edge. disp_req rises in the cycle after the credit reaches PRICE.
- State DISPENSE:
  - disp_req=1 and the timer increments every cycle.
  - disp_ack=1: drop disp_req, pulse newspaper, set credit-=PRICE, go to CHANGE.
  - Timer reaches DISP_TIMEOUT with no ack: drop disp_req, pulse fault, keep the full credit (refund), go to CHANGE.
  - If disp_ack arrives in the same cycle the timer expires, the ack wins.
  - Coin events are rejected; cancel is ignored.
- State CHANGE:
  - If credit==0, go to IDLE immediately with no pulse.
  - Otherwise pulse change_nickel for one cycle per nickel and decrement credit each cycle; go to IDLE in the cycle the credit reaches 0.
  - Coin events are rejected.
- disp_ack outside DISPENSE is ignored.
- Reset asserted mid-dispense or mid-change clears everything. Credit in flight is lost and no pulses are emitted.

Optional Feature:
- Macro: CHANGE_RETURN_EN.
- Defined: CHANGE state as described, so excess credit and refunds are returned as change_nickel pulses.
- Undefined (default, legacy machine behaviour):
  - After a vend, the excess credit is forfeited; credit clears to 0 and the block goes directly to IDLE.
  - cancel is ignored in COLLECT.
  - On timeout, the credit is kept and the block returns to COLLECT so the vend is retried.
  - change_nickel is tied to 0.

Test Plan:
- Three nickels as single-cycle pulses with gaps between them → credit steps 1, 2, 3; disp_req the next cycle; ack after 2 cycles → newspaper pulses once, credit=0, no change_nickel, IDLE.
- Nickel then dime → credit 3 → vend.
- Two dimes → credit 4 → vend.
  - With CHANGE_RETURN_EN: exactly 1 change_nickel pulse.
  - Without it: 0 pulses and credit=0.
- Dime held high for 5 cycles → credited once (credit=2). Quarter in COLLECT with credit 12 → coin_reject pulses and credit stays 12 (test with PRICE=15).
- Credit 3 with disp_ack never asserted → after 8 cycles fault pulses.
  - With CHANGE_RETURN_EN: 3 change_nickel pulses, then IDLE.
  - Without it: back to COLLECT with disp_req reasserted.
- Dime then cancel with CHANGE_RETURN_EN → 2 change_nickel pulses and no newspaper. Reset pulse during DISPENSE → all outputs 0 immediately and credit=0.
